// File: rtl/adc_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module   : adc_serial_rx
//  Brief    : SPI-style master for a 12-bit AD7476-type serial ADC. Starts one
//             conversion per sample period, deserialises the 16-bit frame and
//             presents the 12-bit code zero-extended on X with a one-cycle
//             dato_listo strobe.
//  Revision : 1.0
// ============================================================================
module adc_serial_rx #(
    parameter int ancho  = 13,    // output width, >= 13
    parameter int DIV    = 2,     // clk cycles per SCLK half-period, >= 1
    parameter int FS_DIV = 2267   // clk cycles per sample period, > 32*DIV+2
) (
    input  logic                    clk,
    input  logic                    reset,      // asynchronous, active low
    input  logic                    enable,
    input  logic                    sdata,
    output logic                    sclk,
    output logic                    cs_n,
    output logic signed [ancho-1:0] X,
    output logic                    dato_listo
);

    localparam int TW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
    localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(FS_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(DIV - 1);
    // 16 SCLK periods = 32 half-periods
    localparam logic [4:0]    LAST_HALF = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tick_cnt_q;
    logic [HW-1:0]           div_cnt_q, div_cnt_d;     // clk cycles within a half-period
    logic [4:0]              half_cnt_q, half_cnt_d;   // SCLK half-period index
    // Only 12 bits are kept: the 4 leading frame bits shift out of the top.
    logic [11:0]             shift_q, shift_d;
    logic signed [ancho-1:0] x_q, x_d;
    logic                    dv_q, dv_d;
    logic                    cs_n_q, cs_n_d;
    logic                    sclk_q, sclk_d;
    logic                    tick;

    assign tick = enable && (tick_cnt_q == TICK_LAST);

    // Sample-period counter: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
        end else if (!enable || (tick_cnt_q == TICK_LAST)) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

    // Frame sequencer; outputs are computed one cycle ahead so they leave registers.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        half_cnt_d = half_cnt_q;
        shift_d    = shift_q;
        x_d        = x_q;
        dv_d       = 1'b0;
        cs_n_d     = 1'b1;
        sclk_d     = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d    = CONV;
                    div_cnt_d  = '0;
                    half_cnt_d = '0;
                    cs_n_d     = 1'b0;
                    sclk_d     = 1'b0;   // first half-period is low
                end
            end
            CONV: begin
                cs_n_d = 1'b0;
                sclk_d = sclk_q;
                if (div_cnt_q == HALF_LAST) begin
                    div_cnt_d = '0;
                    if (half_cnt_q == LAST_HALF) begin
                        state_d = DONE;
                        cs_n_d  = 1'b1;
                        sclk_d  = 1'b1;
                        dv_d    = 1'b1;
                        x_d     = {{(ancho-12){1'b0}}, shift_q};
                    end else begin
                        half_cnt_d = half_cnt_q + 5'd1;
                        // Even index -> odd index is the SCLK rising edge: sample here.
                        sclk_d     = ~half_cnt_q[0];
                        if (!half_cnt_q[0]) begin
                            shift_d = {shift_q[10:0], sdata};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + HW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            half_cnt_q <= '0;
            shift_q    <= '0;
            x_q        <= '0;
            dv_q       <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            half_cnt_q <= half_cnt_d;
            shift_q    <= shift_d;
            x_q        <= x_d;
            dv_q       <= dv_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
        end
    end

    assign sclk       = sclk_q;
    assign cs_n       = cs_n_q;
    assign X          = x_q;
    assign dato_listo = dv_q;

endmodule
`default_nettype wire

// File: doc/adc_serial_rx.md
Name: adc_serial_rx

Overview:
- Upstream capture stage of the equaliser input chain. Master for a 12-bit serial ADC (AD7476-style frame: 4 leading zeros, then a 12-bit unsigned code, MSB first).
- Starts one conversion per sample period.
- Deserialises the frame and presents the code as a zero-extended signed word X with a one-cycle valid strobe.
- The offset-removal adder downstream consumes X and applies the offset constant on its Z input, e.g. -2048 for mid-scale.

Parameters:
- ancho, 13, width of output X; must be >= 13.
- DIV, 2, clk cycles per SCLK half-period; must be >= 1.
- FS_DIV, 2267, clk cycles per sample period (100 MHz / 2267 ≈ 44.1 kHz); must be > 32*DIV+2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  conversion enable; sampled each clk.
- sdata  in  1  serial data from the ADC; already synchronous to SCLK.
- sclk  out  1  serial clock to the ADC; idles high.
- cs_n  out  1  ADC chip select, active low.
- X  out  ancho  signed sample = {zeros, code[11:0]}; range 0..4095.
- dato_listo  out  1  one-cycle strobe; X is new in this cycle.

Behaviour:
- Reset (reset=0, immediate, asynchronous):
  - cs_n=1, sclk=1, X=0, dato_listo=0.
  - State=IDLE, tick counter=0, bit counter=0, shift register=0.
  - This applies at any point, including mid-frame. The frame is abandoned and no strobe is issued.
- Tick counter:
  - Counts 0..FS_DIV-1 while enable=1 and wraps to 0.
  - A tick is asserted in the cycle the count equals FS_DIV-1.
  - With enable=0 the counter is held at 0.
- IDLE: cs_n=1, sclk=1. On a tick, go to CONV. cs_n goes low on the next clk edge.
- CONV: cs_n=0 for exactly 32*DIV cycles, i.e. 16 SCLK periods.
  - Each SCLK period is low for DIV cycles, then high for DIV cycles.
  - sdata is shifted into a 16-bit register (MSB first) on the clk edge where sclk goes 0→1.
  - After the 16th rising SCLK period completes, go to DONE.
- DONE (1 cycle):
  - cs_n=1, sclk=1, dato_listo=1.
  - X = zero-extended shift[11:0], registered so it is visible in this same cycle.
  - The leading 4 bits are discarded, even if nonzero.
  - Next state: IDLE.
- X holds its value between strobes. dato_listo is high for exactly one cycle per frame.
- Latency: if cs_n falls at cycle c, dato_listo=1 at cycle c+32*DIV. Consecutive strobes are exactly FS_DIV cycles apart while enable=1.
- enable dropping to 0 mid-frame: the current frame completes normally with its strobe, then the block stays in IDLE.
- enable rising: the first tick occurs FS_DIV-1 cycles later.
- A tick during CONV or DONE cannot occur given the FS_DIV constraint. The verifier asserts that cs_n is high whenever a tick occurs.
- No arithmetic saturation in this block. The output is always non-negative, and the offset sign is handled downstream.

Test Plan:
- Reset held low for 5 cycles, then released with enable=0 for 200 cycles → cs_n=1, sclk=1, X=0, dato_listo=0 throughout.
- DIV=2, FS_DIV=100, enable=1, ADC model drives 0000_1010_1010_1010 → exactly 16 sclk rising edges; cs_n low for 64 cycles; X=13'sd2730 with a single dato_listo pulse on the cycle cs_n returns high; next strobe exactly 100 cycles later.
- ADC model drives codes 0x000, then 0xFFF, then 0x800 → X = 0, 4095, 2048. With Z=-2048 downstream, the adder output is -2048, 2047, 0.
- ADC model drives leading bits 1111 with code 0x123 → X=291; leading bits ignored.
- enable deasserted at cs_n fall + 10 cycles → that frame completes with its strobe; no further cs_n activity. Re-asserting enable → cs_n falls FS_DIV cycles after enable rises.
- reset pulsed low at cs_n fall + 30 cycles → outputs return to reset values immediately; no strobe for the aborted frame. After release, the normal frame cadence resumes.
